// File: rtl/muldiv_unit.sv
// muldiv_unit: multiply/divide unit with HI/LO result registers for the execute stage.
//
// Long operations (mult/multu/div/divu and, optionally, madd/maddu/msub/msubu) latch their
// operands at issue. They keep busy high for MULT_CYCLES or DIV_CYCLES cycles. HI/LO are
// written only on the last busy edge, and done pulses for one cycle after that.
// mtlo/mthi write LO/HI directly from IDLE and do not set busy.
//
// Optional feature macro: MULDIV_MADD_EN. When it is defined, op codes 9-12 decode as
// madd/maddu/msub/msubu. When it is undefined, those codes are no-ops.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      issue strobe; op, a and b are sampled while start=1
//   op         operation code (1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi, 9-12 accumulate)
//   a, b       operands rs / rt
//   rd_hi      read select for out: 1 = HI, 0 = LO
//   out        combinational HI or LO
//   busy       long operation in flight
//   done       one-cycle pulse after HI/LO commit
//   issue_err  one-cycle pulse after start arrives while busy
module muldiv_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hi,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             issue_err
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMtlo  = 4'd5;
  localparam logic [3:0] OpMthi  = 4'd6;
  localparam logic [3:0] OpMadd  = 4'd9;
  localparam logic [3:0] OpMaddu = 4'd10;
  localparam logic [3:0] OpMsub  = 4'd11;
  localparam logic [3:0] OpMsubu = 4'd12;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_d, issue_err_d;
  logic [WIDTH-1:0]  a_q, b_q, hi_q, lo_q, hi_d, lo_d;
  logic [3:0]        op_q;
  logic              is_long, is_div, accept, last;

  // Issue-side decode of the incoming op code.
  always_comb begin
    is_long = 1'b0;
    is_div  = 1'b0;
    case (op)
      OpMult, OpMultu: is_long = 1'b1;
      OpDiv, OpDivu: begin
        is_long = 1'b1;
        is_div  = 1'b1;
      end
`ifdef MULDIV_MADD_EN
      OpMadd, OpMaddu, OpMsub, OpMsubu: is_long = 1'b1;
`endif
      default: ;
    endcase
  end

  assign accept = (state_q == StIdle) && start;
  assign last   = (state_q == StRun) && (cnt_q == CntW'(1));

  // State register, including the registered pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      done      <= 1'b0;
      issue_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done      <= done_d;
      issue_err <= issue_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (start && is_long) begin
          state_d = StRun;
          cnt_d   = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        end
      end
      StRun: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    busy        = (state_q == StRun);
    done_d      = last;
    issue_err_d = start && (state_q == StRun);
  end

  // Operand latch and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (accept && is_long) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op;
      end
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // A single 2*WIDTH multiplier. Signed ops sign-extend their operands, so the low
  // 2*WIDTH bits of the product are the two's-complement result.
  logic                 mul_signed;
  logic [2*WIDTH-1:0]   prod;
  assign mul_signed = (op_q == OpMult) || (op_q == OpMadd) || (op_q == OpMsub);
  assign prod = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q} *
                {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};

  // Divide on magnitudes, then fix the signs: truncate toward zero, and the remainder
  // follows the dividend. most-negative / -1 falls out as LO = most-negative, HI = 0.
  logic             div_signed, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b, q_u, r_u, quot, rem;
  assign div_signed = (op_q == OpDiv);
  assign neg_a      = div_signed & a_q[WIDTH-1];
  assign neg_b      = div_signed & b_q[WIDTH-1];
  assign mag_a      = neg_a ? -a_q : a_q;
  // The zero divisor is replaced by 1 only to keep the divider defined; its result is dropped.
  assign mag_b      = (b_q == '0) ? WIDTH'(1) : (neg_b ? -b_q : b_q);
  assign q_u        = mag_a / mag_b;
  assign r_u        = mag_a % mag_b;
  assign quot       = (neg_a ^ neg_b) ? -q_u : q_u;
  assign rem        = neg_a ? -r_u : r_u;

  // HI/LO next value. accept and last are mutually exclusive because they need different states.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (accept) begin
      case (op)
        OpMtlo: lo_d = a;
        OpMthi: hi_d = a;
        default: ;
      endcase
    end
    if (last) begin
      case (op_q)
        OpMult, OpMultu: {hi_d, lo_d} = prod;
        OpDiv, OpDivu: begin
          if (b_q != '0) begin
            lo_d = quot;
            hi_d = rem;
          end
        end
`ifdef MULDIV_MADD_EN
        OpMadd, OpMaddu: {hi_d, lo_d} = {hi_q, lo_q} + prod;
        OpMsub, OpMsubu: {hi_d, lo_d} = {hi_q, lo_q} - prod;
`endif
        default: ;
      endcase
    end
  end

  assign out = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         rd_hi;
  logic [W-1:0] out;
  logic         busy, done, issue_err;

  int total = 0;
  int bad   = 0;

  // Reference architectural state.
  logic [W-1:0] hi_m, lo_m;

  always #10 clk = ~clk;

  muldiv_unit #(
    .WIDTH      (W),
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .rd_hi    (rd_hi),
    .out      (out),
    .busy     (busy),
    .done     (done),
    .issue_err(issue_err)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_hl(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el);
    rd_hi = 1'b1;
    #1 chk({tag, ".hi"}, out, eh);
    rd_hi = 1'b0;
    #1 chk({tag, ".lo"}, out, el);
  endtask

  function automatic bit madd_en();
`ifdef MULDIV_MADD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_long_op(input logic [3:0] o);
    return (o >= 4'd1 && o <= 4'd4) || (madd_en() && o >= 4'd9 && o <= 4'd12);
  endfunction

  function automatic int lat(input logic [3:0] o);
    return (o == 4'd3 || o == 4'd4) ? int'(DC) : int'(MC);
  endfunction

  // Architectural effect of a completed long op, from plain 64-bit arithmetic.
  function automatic void model(input logic [3:0] o, input logic [W-1:0] x,
                                input logic [W-1:0] y);
    logic [63:0] p, acc;
    longint      sx, sy, q, r;
    if (o == 4'd1 || o == 4'd9 || o == 4'd11)
      p = 64'(longint'($signed(x)) * longint'($signed(y)));
    else
      p = {32'b0, x} * {32'b0, y};
    acc = {hi_m, lo_m};
    case (o)
      4'd1, 4'd2:   {hi_m, lo_m} = p;
      4'd9, 4'd10:  {hi_m, lo_m} = acc + p;
      4'd11, 4'd12: {hi_m, lo_m} = acc - p;
      4'd3: if (y != 0) begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = ((sx < 0) ? -sx : sx) / ((sy < 0) ? -sy : sy);
        if ((sx < 0) != (sy < 0)) q = -q;
        r  = sx - q * sy;
        lo_m = W'(q);
        hi_m = W'(r);
      end
      4'd4: if (y != 0) begin
        lo_m = x / y;
        hi_m = x % y;
      end
      default: ;
    endcase
  endfunction

  // Call at a negedge: drives the strobe across exactly one rising edge.
  task automatic start_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Long op. intr >= 0 injects an mtlo during busy cycle intr. Returns at the done negedge.
  task automatic run_long(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int intr);
    int           n  = lat(o);
    logic [W-1:0] oh = hi_m;
    logic [W-1:0] ol = lo_m;
    model(o, x, y);
    start_op(o, x, y);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (intr >= 0 && i == intr + 1) start = 1'b0;
      chk("issue_err", issue_err, W'(intr >= 0 && i == intr + 1));
      if (i < n) begin
        chk("busy", busy, 1);
        chk("done_low", done, 0);
        if (i == 0) chk_hl("old_val", oh, ol);
        if (i == intr) begin
          start = 1'b1;
          op    = 4'd5;
          a     = $urandom;
        end
      end else begin
        chk("busy_end", busy, 0);
        chk("done_pulse", done, 1);
        chk_hl("commit", hi_m, lo_m);
      end
    end
  endtask

  // Short op or no-op issued from IDLE.
  task automatic run_short(input logic [3:0] o, input logic [W-1:0] x);
    start_op(o, x, $urandom);
    @(negedge clk);
    chk("short_busy", busy, 0);
    chk("short_err", issue_err, 0);
    chk("short_done", done, 0);
    if (o == 4'd5) lo_m = x;
    if (o == 4'd6) hi_m = x;
    chk_hl("short", hi_m, lo_m);
  endtask

  initial begin
    logic [3:0]   ro;
    logic [W-1:0] ra, rb;
    reset = 1'b0;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    rd_hi = 1'b0;
    hi_m  = '0;
    lo_m  = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", issue_err, 0);
    chk_hl("rst", 0, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);

    // Signed multiply, then a back-to-back multiply issued in the done cycle.
    run_long(4'd1, 32'hFFFF_FFFE, 32'd3, -1);
    chk_hl("plan_mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_long(4'd1, 32'd7, 32'hFFFF_FFF7, -1);
    @(negedge clk);

    // Signed divide, then an unsigned divide by zero.
    run_long(4'd3, 32'hFFFF_FFF9, 32'd2, -1);
    chk_hl("plan_div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_long(4'd4, 32'd7, 32'd0, -1);
    chk_hl("plan_div0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_short(4'd6, 32'h1234_5678);
    chk_hl("plan_mthi", 32'h1234_5678, 32'hFFFF_FFFD);

    // mtlo injected during a mult is rejected.
    run_long(4'd1, 32'd100, 32'd200, 2);
    chk_hl("plan_intr", 32'd0, 32'd20000);

    // Signed overflow.
    run_long(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk_hl("div_ovf", 32'd0, 32'h8000_0000);

`ifdef MULDIV_MADD_EN
    run_short(4'd6, 32'd0);
    run_short(4'd5, 32'hFFFF_FFFF);
    run_long(4'd10, 32'd1, 32'd1, -1);
    chk_hl("plan_maddu", 32'd1, 32'd0);
    run_long(4'd11, 32'd1, 32'd2, -1);
    chk_hl("plan_msub", 32'd0, 32'hFFFF_FFFE);
`else
    run_short(4'd9, 32'd5);
    chk_hl("plan_nomadd", 32'd0, 32'h8000_0000);
`endif
    run_short(4'd0, 32'hDEAD_BEEF);
    run_short(4'd7, 32'hDEAD_BEEF);

    // Asynchronous reset during the third busy cycle of a divide.
    start_op(4'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk_hl("arst", 0, 0);
    hi_m = '0;
    lo_m = '0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("arst_nodone", done, 0);
    chk("arst_idle", busy, 0);
    run_long(4'd1, 32'd3, 32'd4, -1);
    chk_hl("arst_mult", 32'd0, 32'd12);

    // Random operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 9));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if (is_long_op(ro))
        run_long(ro, ra, rb,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat(ro) - 1)) : -1);
      else
        run_short(ro, ra);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multiply/divide unit with HI/LO result registers for the CPU execute stage.
- Successor to the fixed 32-bit, fixed-latency mult/div block:
  - width and latencies are parameters;
  - operands are latched at start, and results commit only at completion;
  - adds a done pulse and protection against illegal issue.
- The pipeline stalls on `busy`.
- mfhi/mflo read the unit through a combinational port.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (≥ 2).
- MULT_CYCLES, 5, busy cycles for mult/multu/madd-class operations (≥ 1).
- DIV_CYCLES, 10, busy cycles for div/divu (≥ 1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  issue strobe; `op` is sampled when start=1.
- op  in  4  operation code:
  - 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi
  - 9 madd, 10 maddu, 11 msub, 12 msubu
  - all other codes: no-op
- a  in  WIDTH  operand rs.
- b  in  WIDTH  operand rt.
- rd_hi  in  1  read select: 1 = HI, 0 = LO.
- out  out  WIDTH  combinational value of HI if rd_hi=1, otherwise LO.
- busy  out  1  long operation in flight.
- done  out  1  one-cycle pulse when HI/LO commit at the end of a long operation.
- issue_err  out  1  one-cycle pulse when start=1 arrives while busy=1.

Behaviour:
- Reset (asynchronous, reset=0): HI=0, LO=0, busy=0, done=0, issue_err=0, counter=0, latched operands=0. Any in-flight operation is discarded and HI/LO are not updated.
- States:
  - IDLE
  - RUN: counter counts down from the latency value.
- IDLE with start=1:
  - op 5 (mtlo): LO<=a at this edge; busy stays 0.
  - op 6 (mthi): HI<=a at this edge; busy stays 0.
  - Long ops (1–4, 9–12):
    - latch a, b and op; load counter = MULT_CYCLES or DIV_CYCLES;
    - go to RUN; busy=1 from the next cycle;
    - HI/LO remain readable with their old values throughout RUN.
  - Other op codes: no effect.
- RUN:
  - The counter decrements each cycle.
  - On the edge where counter reaches 1:
    - HI/LO commit;
    - busy<=0 and done<=1 (1 cycle);
    - return to IDLE.
  - Net effect: busy is high for exactly N cycles, where N is the latency parameter.
  - A new start is accepted in the first cycle after busy falls.
- start=1 while busy=1: the request is ignored, issue_err pulses for 1 cycle, and the in-flight operation is unaffected. This includes mtlo/mthi.
- Arithmetic, using the latched operands:
  - mult: {HI,LO} = signed a × signed b, full 2·WIDTH product.
  - multu: the same, unsigned.
  - div: LO = quotient, HI = remainder.
    - Signed, truncated toward zero; the remainder takes the sign of the dividend.
  - divu: the same, unsigned.
  - Divide by zero (b=0): the operation still runs DIV_CYCLES and pulses done, but HI/LO stay unchanged.
  - Signed overflow (most-negative / −1): LO = most-negative value, HI = 0.
  - madd/maddu: {HI,LO} = {HI,LO} + product, signed/unsigned, mod 2^(2·WIDTH).
  - msub/msubu: {HI,LO} = {HI,LO} − product, mod 2^(2·WIDTH).
  - Accumulate ops use the HI/LO values present at commit time.
    - HI/LO cannot change during RUN, so this equals the value at start.
- `out` is purely combinational from HI/LO and rd_hi; it has no dependency on op.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- When defined, op codes 9–12 are decoded as madd/maddu/msub/msubu, exactly as specified above.
- When undefined:
  - op codes 9–12 are no-ops: no busy, no issue_err from IDLE, and HI/LO unchanged;
  - the accumulate adder is not synthesised.

Test Plan:
- Reset released, then mult with a=0xFFFFFFFE (−2), b=3, WIDTH=32 → busy high for exactly 5 cycles; HI=0xFFFFFFFF and LO=0xFFFFFFFA at the edge where done pulses; out shows the old values until then.
- div with a=−7 (0xFFFFFFF9), b=2 → after 10 busy cycles LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). divu with a=7, b=0 → done pulses, HI/LO unchanged.
- mthi a=0x12345678 from IDLE → HI=0x12345678 the next cycle, busy never asserted. mtlo issued mid-mult → issue_err pulse, LO unaffected, mult result commits normally.
- MULDIV_MADD_EN defined: mthi 0, mtlo 0xFFFFFFFF, then maddu a=1, b=1 → HI=1, LO=0. Then msub a=1, b=2 → HI=0, LO=0xFFFFFFFE. Undefined: op 9 → no busy, HI/LO unchanged.
- reset driven low during cycle 3 of a div → busy=0, HI=LO=0 immediately (asynchronous), no done pulse; a mult issued after release completes normally.
- Back-to-back: a second mult with start asserted the cycle after done → accepted with no issue_err; busy high for 5 cycles again.
